// File: rtl/cs_address_sequencer_pkg.sv
// cs_address_sequencer_pkg: shared COND encodings, FSM states and reset/decode constants
package cs_address_sequencer_pkg;
    typedef enum logic [2:0] {
        COND_NEXT   = 3'b000,
        COND_N      = 3'b001,
        COND_Z      = 3'b010,
        COND_V      = 3'b011,
        COND_C      = 3'b100,
        COND_IR13   = 3'b101,
        COND_JUMP   = 3'b110,
        COND_DECODE = 3'b111
    } cond_e;
    typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_e;
    localparam logic [10:0] CS_RESET_ADDR = 11'd0;
    localparam logic DECODE_PREFIX = 1'b1;
endpackage

// File: rtl/cs_address_sequencer_next_address.sv
// cs_next_address: combinational next control-store address (COND mux, flag select, CSAI, opcode decode)
module cs_next_address
    import cs_address_sequencer_pkg::*;
#(
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_CONDITION   = 3,
    parameter int DATAWIDTH_OP          = 2,
    parameter int DATAWIDTH_OP3         = 6
) (
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] address,
    input  logic [DATAWIDTH_CONDITION-1:0]   condition,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] jump_address,
    input  logic [3:0]                       flags,
    input  logic [DATAWIDTH_OP-1:0]          op,
    input  logic [DATAWIDTH_OP3-1:0]         op3,
    input  logic                             ir13,
    output logic [DATAWIDTH_JUMPADDRESS-1:0] next_address
);
    logic [DATAWIDTH_JUMPADDRESS-1:0] csai;
    logic [DATAWIDTH_JUMPADDRESS-1:0] decode;
    logic                             take;
    always_comb begin
        csai   = address + 1'b1;
        decode = {DECODE_PREFIX, op, op3, 2'b00};
        take   = condition == COND_N    ? flags[3] :
                 condition == COND_Z    ? flags[2] :
                 condition == COND_V    ? flags[1] :
                 condition == COND_C    ? flags[0] :
                 condition == COND_IR13 ? ir13 :
                 condition == COND_JUMP;
        next_address = condition == COND_DECODE ? decode : take ? jump_address : csai;
    end
endmodule

// File: rtl/cs_address_sequencer.sv
// cs_address_sequencer: control-store address register plus RUN/WAIT memory-stall FSM.
// Optional CS_ADDRESS_SEQUENCER_SINGLE_STEP_EN adds Step_In gating of RUN-state advances.
module cs_address_sequencer
    import cs_address_sequencer_pkg::*;
#(
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_CONDITION   = 3,
    parameter int DATAWIDTH_OP          = 2,
    parameter int DATAWIDTH_OP3         = 6
) (
    input  logic                             CS_ADDRESS_SEQUENCER_CLOCK_50,
    input  logic                             CS_ADDRESS_SEQUENCER_ResetInLow_In,
    input  logic [DATAWIDTH_CONDITION-1:0]   CS_ADDRESS_SEQUENCER_Condition_InBus,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_JumpAddress_InBus,
    input  logic                             CS_ADDRESS_SEQUENCER_RD_In,
    input  logic                             CS_ADDRESS_SEQUENCER_WR_In,
    input  logic                             CS_ADDRESS_SEQUENCER_MemAck_In,
    input  logic [3:0]                       CS_ADDRESS_SEQUENCER_Flags_InBus,
    input  logic [DATAWIDTH_OP-1:0]          CS_ADDRESS_SEQUENCER_Op_InBus,
    input  logic [DATAWIDTH_OP3-1:0]         CS_ADDRESS_SEQUENCER_Op3_InBus,
    input  logic                             CS_ADDRESS_SEQUENCER_IR13_In,
`ifdef CS_ADDRESS_SEQUENCER_SINGLE_STEP_EN
    input  logic                             CS_ADDRESS_SEQUENCER_Step_In,
`endif
    output logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_CSAddress_OutBus,
    output logic                             CS_ADDRESS_SEQUENCER_Stall_Out
);
    logic [DATAWIDTH_JUMPADDRESS-1:0] next_address;
    logic                             request;
    logic                             ack;
    logic                             step;
    state_e                           state;
    assign request = CS_ADDRESS_SEQUENCER_RD_In | CS_ADDRESS_SEQUENCER_WR_In;
    assign ack     = CS_ADDRESS_SEQUENCER_MemAck_In;
`ifdef CS_ADDRESS_SEQUENCER_SINGLE_STEP_EN
    assign step = CS_ADDRESS_SEQUENCER_Step_In;
`else
    assign step = 1'b1;
`endif
    cs_next_address #(
        .DATAWIDTH_JUMPADDRESS(DATAWIDTH_JUMPADDRESS),
        .DATAWIDTH_CONDITION  (DATAWIDTH_CONDITION),
        .DATAWIDTH_OP         (DATAWIDTH_OP),
        .DATAWIDTH_OP3        (DATAWIDTH_OP3)
    ) u_next (
        .address     (CS_ADDRESS_SEQUENCER_CSAddress_OutBus),
        .condition   (CS_ADDRESS_SEQUENCER_Condition_InBus),
        .jump_address(CS_ADDRESS_SEQUENCER_JumpAddress_InBus),
        .flags       (CS_ADDRESS_SEQUENCER_Flags_InBus),
        .op          (CS_ADDRESS_SEQUENCER_Op_InBus),
        .op3         (CS_ADDRESS_SEQUENCER_Op3_InBus),
        .ir13        (CS_ADDRESS_SEQUENCER_IR13_In),
        .next_address(next_address)
    );
    // Stall is registered alongside the state so it never depends combinationally on inputs.
    always_ff @(posedge CS_ADDRESS_SEQUENCER_CLOCK_50) begin
        if (!CS_ADDRESS_SEQUENCER_ResetInLow_In) begin
            CS_ADDRESS_SEQUENCER_CSAddress_OutBus <= CS_RESET_ADDR;
            CS_ADDRESS_SEQUENCER_Stall_Out        <= 1'b0;
            state                                 <= ST_RUN;
        end else if (state == ST_WAIT) begin
            if (ack) begin
                CS_ADDRESS_SEQUENCER_CSAddress_OutBus <= next_address;
                CS_ADDRESS_SEQUENCER_Stall_Out        <= 1'b0;
                state                                 <= ST_RUN;
            end
        end else if (!step) begin
            CS_ADDRESS_SEQUENCER_Stall_Out <= 1'b1;
        end else if (request && !ack) begin
            CS_ADDRESS_SEQUENCER_Stall_Out <= 1'b1;
            state                          <= ST_WAIT;
        end else begin
            CS_ADDRESS_SEQUENCER_CSAddress_OutBus <= next_address;
            CS_ADDRESS_SEQUENCER_Stall_Out        <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cs_address_sequencer.sv
// tb_cs_address_sequencer: directed self-checking bench for cs_address_sequencer
module tb_cs_address_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  cond;
    logic [10:0] jump;
    logic        rd;
    logic        wr;
    logic        ack;
    logic [3:0]  flags;
    logic [1:0]  op;
    logic [5:0]  op3;
    logic        ir13;
    logic        step;
    logic [10:0] addr;
    logic        stall;
    int          total = 0;
    int          passed = 0;
    always #5 clk = ~clk;
    cs_address_sequencer dut (
        .CS_ADDRESS_SEQUENCER_CLOCK_50         (clk),
        .CS_ADDRESS_SEQUENCER_ResetInLow_In    (rst_n),
        .CS_ADDRESS_SEQUENCER_Condition_InBus  (cond),
        .CS_ADDRESS_SEQUENCER_JumpAddress_InBus(jump),
        .CS_ADDRESS_SEQUENCER_RD_In            (rd),
        .CS_ADDRESS_SEQUENCER_WR_In            (wr),
        .CS_ADDRESS_SEQUENCER_MemAck_In        (ack),
        .CS_ADDRESS_SEQUENCER_Flags_InBus      (flags),
        .CS_ADDRESS_SEQUENCER_Op_InBus         (op),
        .CS_ADDRESS_SEQUENCER_Op3_InBus        (op3),
        .CS_ADDRESS_SEQUENCER_IR13_In          (ir13),
`ifdef CS_ADDRESS_SEQUENCER_SINGLE_STEP_EN
        .CS_ADDRESS_SEQUENCER_Step_In          (step),
`endif
        .CS_ADDRESS_SEQUENCER_CSAddress_OutBus (addr),
        .CS_ADDRESS_SEQUENCER_Stall_Out        (stall)
    );
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [10:0] ea, input logic es);
        total++;
        assert (addr === ea && stall === es) passed++;
        else $error("FAIL %s: addr=%0d stall=%b, expected addr=%0d stall=%b", tag, addr, stall, ea, es);
    endtask
    initial begin
        rst_n = 1'b0; cond = 3'b000; jump = '0; rd = 1'b0; wr = 1'b0; ack = 1'b0;
        flags = 4'b0000; op = 2'b00; op3 = 6'b0; ir13 = 1'b0; step = 1'b1;
        cyc(); chk("reset", 11'd0, 1'b0);
        rst_n = 1'b1;
        cyc(); chk("csai1", 11'd1, 1'b0);
        cyc(); chk("csai2", 11'd2, 1'b0);
        cyc(); chk("csai3", 11'd3, 1'b0);
        rst_n = 1'b0; cyc(); chk("reset2", 11'd0, 1'b0);
        rst_n = 1'b1; cyc(); chk("csai_to1", 11'd1, 1'b0);
        cond = 3'b111; op = 2'b10; op3 = 6'b010000;
        cyc(); chk("decode", 11'd1600, 1'b0);
        cond = 3'b101; jump = 11'd1602; ir13 = 1'b1;
        cyc(); chk("ir13_taken", 11'd1602, 1'b0);
        cond = 3'b110; jump = 11'd1600;
        cyc(); chk("jump", 11'd1600, 1'b0);
        cond = 3'b101; jump = 11'd1602; ir13 = 1'b0;
        cyc(); chk("ir13_not", 11'd1601, 1'b0);
        cond = 3'b010; flags = 4'b1011; jump = 11'd5;
        cyc(); chk("z_not", 11'd1602, 1'b0);
        flags = 4'b0100;
        cyc(); chk("z_taken", 11'd5, 1'b0);
        cond = 3'b001; flags = 4'b1000; jump = 11'd100;
        cyc(); chk("n_taken", 11'd100, 1'b0);
        cond = 3'b011; flags = 4'b1101; jump = 11'd900;
        cyc(); chk("v_not", 11'd101, 1'b0);
        cond = 3'b100; flags = 4'b0001; jump = 11'd7;
        cyc(); chk("c_taken", 11'd7, 1'b0);
        cond = 3'b110; jump = 11'd2047;
        cyc(); chk("jump_max", 11'd2047, 1'b0);
        cond = 3'b000;
        cyc(); chk("wrap", 11'd0, 1'b0);
        rd = 1'b1;
        cyc(); chk("wait1", 11'd0, 1'b1);
        cyc(); chk("wait2", 11'd0, 1'b1);
        cyc(); chk("wait3", 11'd0, 1'b1);
        ack = 1'b1;
        cyc(); chk("ack_release", 11'd1, 1'b0);
        rd = 1'b0; wr = 1'b1;
        cyc(); chk("same_cycle_ack", 11'd2, 1'b0);
        rd = 1'b1; ack = 1'b0;
        cyc(); chk("rdwr_wait", 11'd2, 1'b1);
        ack = 1'b1;
        cyc(); chk("rdwr_release", 11'd3, 1'b0);
        rd = 1'b0; wr = 1'b0;
        cyc(); chk("stray_ack", 11'd4, 1'b0);
        rd = 1'b1; ack = 1'b0;
        cyc(); chk("wait_pre_reset", 11'd4, 1'b1);
        rst_n = 1'b0;
        cyc(); chk("reset_in_wait", 11'd0, 1'b0);
        rst_n = 1'b1; rd = 1'b0;
        cyc(); chk("after_reset", 11'd1, 1'b0);
        rd = 1'b1;
        cyc(); chk("wait_cond", 11'd1, 1'b1);
        cond = 3'b110; jump = 11'd500; ack = 1'b1;
        cyc(); chk("ack_uses_cond", 11'd500, 1'b0);
        rd = 1'b0; ack = 1'b0; cond = 3'b000;
`ifdef CS_ADDRESS_SEQUENCER_SINGLE_STEP_EN
        for (int p = 0; p < 3; p++) begin
            step = 1'b0;
            for (int k = 0; k < 3; k++) begin
                cyc(); chk("step_hold", 11'(500 + p), 1'b1);
            end
            step = 1'b1;
            cyc(); chk("step_adv", 11'(501 + p), 1'b0);
        end
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cs_address_sequencer.md
# cs_address_sequencer

Control-section address sequencer for the micro-datapath: closes the loop around the microcode store by registering the current control-store address and computing the next one. Inputs are the microinstruction's condition and jump-address fields, the ALU flags and the instruction-register fields. It selects among increment (CSAI), conditional or unconditional jump, and opcode decode. It also stalls the sequence while a main-memory read/write is outstanding.

## Interface
Parameters:
- DATAWIDTH_JUMPADDRESS, 11: control-store address width.
- DATAWIDTH_CONDITION, 3: condition-field width.
- DATAWIDTH_OP, 2: IR[31:30] width.
- DATAWIDTH_OP3, 6: IR[24:19] width.

Ports (name, direction, width, meaning):
- CS_ADDRESS_SEQUENCER_CLOCK_50, in, 1: single clock; all state updates on posedge.
- CS_ADDRESS_SEQUENCER_ResetInLow_In, in, 1: reset, synchronous, active-low.
- CS_ADDRESS_SEQUENCER_Condition_InBus, in, 3: microinstruction COND field.
- CS_ADDRESS_SEQUENCER_JumpAddress_InBus, in, 11: microinstruction JUMP ADDR field.
- CS_ADDRESS_SEQUENCER_RD_In / _WR_In, in, 1 each: microinstruction memory read/write request.
- CS_ADDRESS_SEQUENCER_MemAck_In, in, 1: main memory completion strobe, one cycle.
- CS_ADDRESS_SEQUENCER_Flags_InBus, in, 4: {n,z,v,c} from PSR.
- CS_ADDRESS_SEQUENCER_Op_InBus, in, 2: IR[31:30].
- CS_ADDRESS_SEQUENCER_Op3_InBus, in, 6: IR[24:19].
- CS_ADDRESS_SEQUENCER_IR13_In, in, 1: IR[13] (immediate select).
- CS_ADDRESS_SEQUENCER_CSAddress_OutBus, out, 11: registered current control-store address.
- CS_ADDRESS_SEQUENCER_Stall_Out, out, 1: high while in WAIT; datapath must inhibit register writes.

## Operation
- COND decode, next address when not stalled:
  - 000: CSAI = CSAddress+1.
  - 001: JumpAddress if n, else CSAI.
  - 010: JumpAddress if z, else CSAI.
  - 011: JumpAddress if v, else CSAI.
  - 100: JumpAddress if c, else CSAI.
  - 101: JumpAddress if IR13, else CSAI.
  - 110: JumpAddress unconditionally.
  - 111: DECODE = {1'b1, Op, Op3, 2'b00}.
- CSAI wraps 2047 -> 0; no carry out.
- FSM states:
  - RUN: if (RD|WR) and !MemAck -> WAIT, address held. Otherwise load next address.
  - WAIT: hold address; on MemAck -> RUN and load next address, using COND/flags sampled that cycle.
- RD and WR both high is treated as one request.
- MemAck in RUN without a request is ignored.

## Timing
- Reset (ResetInLow_In=0 at posedge): CSAddress=0, state RUN, Stall_Out=0. Reset wins over every other input, including mid-WAIT.
- Microcode store presents fields on negedge. Sequencer samples them on the following posedge, so one microinstruction executes per clock when not stalled.
- Request with MemAck in the same cycle: zero stall; Stall_Out is never asserted.
- Request without ack: Stall_Out rises after that posedge, stays high until the posedge that samples MemAck=1, then drops. Stall length = cycles until ack.
- Stall_Out is a registered decode of the state; it has no combinational path from inputs.

## Configuration
- CS_ADDRESS_SEQUENCER_SINGLE_STEP_EN defined:
  - Adds input CS_ADDRESS_SEQUENCER_Step_In (1 bit, one-cycle pulse).
  - In RUN, the address advances only on a cycle with Step_In=1; otherwise it holds and Stall_Out=1.
  - WAIT behaviour is unchanged; Step_In is ignored in WAIT.
- Undefined: no port; the sequencer free-runs.

## Structure
- Shared package holds:
  - COND encodings (COND_NEXT … COND_DECODE).
  - FSM state encodings.
  - CS_RESET_ADDR = 11'd0.
  - DECODE_PREFIX = 1'b1.
- One combinational sub-module, cs_next_address: COND mux, flag select, CSAI incrementer and decode-address formation.
- The top holds the address register and the FSM.

## Test plan
- Reset then COND=000 for 3 cycles -> CSAddress 0,1,2,3; Stall_Out=0 throughout.
- At address 1, COND=111, Op=2'b10, Op3=6'b010000 -> next CSAddress=11'b11001000000 (1600).
- COND=101, Jump=1602: IR13=1 -> 1602; IR13=0 from 1600 -> 1601. COND=010, z=0 -> CSAI.
- RD=1 at address 0, MemAck arrives 3 cycles later -> CSAddress holds 0, Stall_Out high 3 cycles, then 1. Repeat with same-cycle ack -> 1 next cycle, no stall.
- Reset asserted during WAIT -> CSAddress=0, Stall_Out=0 at that posedge. COND=000 at 2047 -> 0.
- With SINGLE_STEP_EN: Step_In pulsed every 4th cycle -> address advances once per pulse, Stall_Out high in between.
